// File: rtl/i2s_transceiver.sv
// i2s_transceiver: I2S master generating MCLK/BCLK/LRCLK, stereo TX and RX.
// Optional I2S_LOOPBACK_EN adds a loopback input that retransmits captured RX.
module i2s_transceiver #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int MCLK_DIV  = 4,
  parameter int BCLK_HALF = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] tx_left,
  input  logic [SAMPLE_W-1:0] tx_right,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic [SAMPLE_W-1:0] rx_left,
  output logic [SAMPLE_W-1:0] rx_right,
  output logic                rx_valid,
  output logic                busy,
  output logic                mclk,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdout,
  input  logic                sdin
`ifdef I2S_LOOPBACK_EN
  ,
  input  logic                loopback
`endif
);

  localparam int MW    = $clog2(MCLK_DIV);
  localparam int HW    = $clog2(BCLK_HALF);
  localparam int BW    = $clog2(SLOT_W);
  localparam int MHALF = MCLK_DIV / 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [MW-1:0] mclk_cnt;
  logic [HW-1:0] half_q;
  logic [BW-1:0] b_q;
  logic [BW-1:0] b_nx;

  logic tick;
  logic rise;
  logic fall;
  logic b_wrap;
  logic lr_nx;
  logic frame_end;
  logic enter;
  logic frame_start;
  logic stop;
  logic tx_bit_en;
  logic rx_bit_en;
  logic rx_done;
  logic use_loop;
  logic accept;
  logic hold_full;
  logic sdin_m;
  logic sdin_s;

  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic [SAMPLE_W-1:0] ld_l;
  logic [SAMPLE_W-1:0] ld_r;
  logic [SAMPLE_W-1:0] tx_l_sh;
  logic [SAMPLE_W-1:0] tx_r_sh;
  logic [SAMPLE_W-1:0] rx_l_sh;
  logic [SAMPLE_W-1:0] rx_r_sh;
  logic [SAMPLE_W-1:0] rx_l_nx;
  logic [SAMPLE_W-1:0] rx_r_nx;

`ifdef I2S_LOOPBACK_EN
  assign use_loop = loopback;
`else
  assign use_loop = 1'b0;
`endif

  assign tick      = (state_q != IDLE) &&
                     (half_q == HW'(BCLK_HALF - 1));
  assign rise      = tick && !bclk;
  assign fall      = tick && bclk;
  assign b_wrap    = (b_q == BW'(SLOT_W - 1));
  assign b_nx      = b_wrap ? '0 : b_q + BW'(1);
  assign lr_nx     = b_wrap ? ~lrclk : lrclk;
  assign frame_end = fall && b_wrap && lrclk;
  assign enter     = (state_q == IDLE) && en;

  // A frame boundary keeps running unless an undisturbed drain ends here.
  assign frame_start = enter ||
                       (frame_end && (state_q == RUN || en));
  assign stop        = frame_end && (state_q == DRAIN) && !en;

  assign tx_bit_en = fall && (b_nx != '0) &&
                     (b_nx <= BW'(SAMPLE_W));
  assign rx_bit_en = rise && (b_q != '0) &&
                     (b_q <= BW'(SAMPLE_W));
  assign rx_done   = rx_bit_en && lrclk &&
                     (b_q == BW'(SAMPLE_W));

  assign accept   = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign busy     = (state_q != IDLE);

  assign ld_l = use_loop ? rx_left :
                (hold_full ? hold_l : '0);
  assign ld_r = use_loop ? rx_right :
                (hold_full ? hold_r : '0);

  assign rx_l_nx = SAMPLE_W'({rx_l_sh, sdin_s});
  assign rx_r_nx = SAMPLE_W'({rx_r_sh, sdin_s});

  // Free-running codec master clock, independent of the run state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt == MW'(MHALF - 1)) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + MW'(1);
    end
  end

  // Run-state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: drain finishes the frame in flight before idling.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (en) state_d = RUN;
        else if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // BCLK half-period counter, bit index and word select.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      half_q <= '0;
      bclk   <= 1'b0;
      b_q    <= '0;
      lrclk  <= 1'b0;
    end else if (enter) begin
      half_q <= '0;
      bclk   <= 1'b0;
      b_q    <= '0;
      lrclk  <= 1'b0;
    end else if (state_q != IDLE) begin
      if (tick) begin
        half_q <= '0;
        bclk   <= ~bclk;
      end else begin
        half_q <= half_q + HW'(1);
      end
      if (fall) begin
        b_q   <= b_nx;
        lrclk <= lr_nx;
      end
    end
  end

  // Holding register: one pair queued ahead of the frame on the wire.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l    <= tx_left;
      hold_r    <= tx_right;
    end else if (frame_start && !use_loop) begin
      hold_full <= 1'b0;
    end
  end

  // TX shifters: load at frame start, emit MSB-first on falling edges.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_l_sh     <= '0;
      tx_r_sh     <= '0;
      sdout       <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= frame_start && !hold_full && !use_loop;
      if (frame_start) begin
        tx_l_sh <= ld_l;
        tx_r_sh <= ld_r;
      end else if (tx_bit_en) begin
        if (lr_nx) tx_r_sh <= tx_r_sh << 1;
        else tx_l_sh <= tx_l_sh << 1;
      end
      if (enter) begin
        sdout <= 1'b0;
      end else if (fall) begin
        sdout <= tx_bit_en &&
                 (lr_nx ? tx_r_sh[SAMPLE_W-1]
                        : tx_l_sh[SAMPLE_W-1]);
      end
    end
  end

  // Two-stage synchroniser for the codec data line.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sdin_m <= 1'b0;
      sdin_s <= 1'b0;
    end else begin
      sdin_m <= sdin;
      sdin_s <= sdin_m;
    end
  end

  // RX shifters sample on rising edges; publish both channels together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_l_sh  <= '0;
      rx_r_sh  <= '0;
      rx_left  <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      if (rx_bit_en) begin
        if (lrclk) rx_r_sh <= rx_r_nx;
        else rx_l_sh <= rx_l_nx;
      end
      if (rx_done) begin
        rx_left  <= rx_l_sh;
        rx_right <= rx_r_nx;
      end
    end
  end

endmodule
